// File: rtl/morse_sequencer.sv
// morse_sequencer: queues 3-bit letter codes (A-H) and sends them as Morse on one light,
// timing marks, spaces and letter gaps in units of an external tick strobe.
`default_nettype none

module morse_sequencer #(
    parameter int FIFO_DEPTH       = 4,
    parameter int DOT_UNITS        = 1,
    parameter int DASH_UNITS       = 3,
    parameter int LETTER_GAP_UNITS = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick_i,
    input  logic [2:0]                  letter_i,
    input  logic                        letter_valid_i,
    output logic                        letter_ready_o,
    output logic                        light_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        letter_done_o
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int MAXU = (DASH_UNITS > LETTER_GAP_UNITS) ? DASH_UNITS : LETTER_GAP_UNITS;
    localparam int UW   = $clog2(MAXU) + 1;

    localparam logic [UW-1:0] DOT_U  = UW'(DOT_UNITS);
    localparam logic [UW-1:0] DASH_U = UW'(DASH_UNITS);
    localparam logic [UW-1:0] GAP_U  = UW'(LETTER_GAP_UNITS);
    localparam logic [UW-1:0] ONE_U  = UW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MARK  = 3'd2;
    localparam logic [2:0] S_SPACE = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    logic [2:0]    state_q, state_d;
    logic [2:0]    letter_q, letter_d;
    logic [3:0]    pat_q, pat_d;
    logic [1:0]    rem_q, rem_d;
    logic [UW-1:0] cnt_q, cnt_d;
    logic          light_q, done_q, done_d;

    logic          push_w, pop_w;
    logic [3:0]    tbl_pat_w;
    logic [1:0]    tbl_rem_w;

    assign letter_ready_o = (count_q != (AW+1)'(FIFO_DEPTH));
    assign push_w         = letter_valid_i && letter_ready_o;
    assign pop_w          = (state_q == S_IDLE) && (count_q != '0);

    assign light_o       = light_q;
    assign busy_o        = (state_q != S_IDLE);
    assign fifo_count_o  = count_q;
    assign letter_done_o = done_q;

    // Pattern bit i is symbol i (1 = dash); rem holds symbol count minus one.
    always_comb begin
        tbl_pat_w = 4'b0000;
        tbl_rem_w = 2'd0;
        case (letter_q)
            3'd0: begin tbl_pat_w = 4'b0010; tbl_rem_w = 2'd1; end
            3'd1: begin tbl_pat_w = 4'b0001; tbl_rem_w = 2'd3; end
            3'd2: begin tbl_pat_w = 4'b0101; tbl_rem_w = 2'd3; end
            3'd3: begin tbl_pat_w = 4'b0001; tbl_rem_w = 2'd2; end
            3'd4: begin tbl_pat_w = 4'b0000; tbl_rem_w = 2'd0; end
            3'd5: begin tbl_pat_w = 4'b0100; tbl_rem_w = 2'd3; end
            3'd6: begin tbl_pat_w = 4'b0011; tbl_rem_w = 2'd2; end
            default: begin tbl_pat_w = 4'b0000; tbl_rem_w = 2'd3; end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push_w && !pop_w)
            count_d = count_q + 1'b1;
        else if (!push_w && pop_w)
            count_d = count_q - 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        letter_d = letter_q;
        pat_d    = pat_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop_w) begin
                    letter_d = mem_q[rd_ptr_q];
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = tbl_pat_w[0] ? DASH_U : DOT_U;
                pat_d   = {1'b0, tbl_pat_w[3:1]};
                rem_d   = tbl_rem_w;
                state_d = S_MARK;
            end
            S_MARK: begin
                if (tick_i) begin
                    if (cnt_q == ONE_U) begin
                        if (rem_q != 2'd0) begin
                            cnt_d   = ONE_U;
                            state_d = S_SPACE;
                        end else begin
                            cnt_d   = GAP_U;
                            state_d = S_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_SPACE: begin
                if (tick_i) begin
                    if (cnt_q == ONE_U) begin
                        cnt_d   = pat_q[0] ? DASH_U : DOT_U;
                        pat_d   = {1'b0, pat_q[3:1]};
                        rem_d   = rem_q - 1'b1;
                        state_d = S_MARK;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (tick_i) begin
                    if (cnt_q == ONE_U) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_w)
            mem_q[wr_ptr_q] <= letter_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            letter_q <= 3'd0;
            pat_q    <= 4'd0;
            rem_q    <= 2'd0;
            cnt_q    <= '0;
            light_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (push_w)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_d;
            state_q  <= state_d;
            letter_q <= letter_d;
            pat_q    <= pat_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            light_q  <= (state_d == S_MARK);
            done_q   <= done_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_morse_sequencer.sv
// tb_morse_sequencer: directed and random stimulus checked cycle-by-cycle against a
// segment-list reference model built from the Morse string table.
`default_nettype none

module tb_morse_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int DOT_UNITS  = 1;
    localparam int DASH_UNITS = 3;
    localparam int GAP_UNITS  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_i;
    logic [2:0] letter_i;
    logic       letter_valid_i;
    logic       letter_ready_o;
    logic       light_o;
    logic       busy_o;
    logic [2:0] fifo_count_o;
    logic       letter_done_o;

    int n_checks = 0;
    int n_errors = 0;

    morse_sequencer #(
        .FIFO_DEPTH      (FIFO_DEPTH),
        .DOT_UNITS       (DOT_UNITS),
        .DASH_UNITS      (DASH_UNITS),
        .LETTER_GAP_UNITS(GAP_UNITS)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_i        (tick_i),
        .letter_i      (letter_i),
        .letter_valid_i(letter_valid_i),
        .letter_ready_o(letter_ready_o),
        .light_o       (light_o),
        .busy_o        (busy_o),
        .fifo_count_o  (fifo_count_o),
        .letter_done_o (letter_done_o)
    );

    always #5 clk = ~clk;

    // Reference model: a letter is a list of timed segments (mark, space, ..., gap).
    string m_tbl [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
    int    m_q [$];
    int    m_segs [$];
    bit    m_mark [$];
    int    m_phase;
    int    m_cur;
    int    m_seg;
    int    m_left;
    bit    m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_segs.delete();
        m_mark.delete();
        m_phase = 0;
        m_cur   = 0;
        m_seg   = 0;
        m_left  = 0;
        m_done  = 1'b0;
    endtask

    task automatic model_step(input bit v, input int l, input bit t);
        bit rdy;
        string s;
        rdy    = (m_q.size() < FIFO_DEPTH);
        m_done = 1'b0;
        case (m_phase)
            0: if (m_q.size() != 0) begin
                m_cur   = m_q.pop_front();
                m_phase = 1;
            end
            1: begin
                s = m_tbl[m_cur];
                m_segs.delete();
                m_mark.delete();
                for (int i = 0; i < s.len(); i++) begin
                    m_segs.push_back((s[i] == "-") ? DASH_UNITS : DOT_UNITS);
                    m_mark.push_back(1'b1);
                    if (i < s.len() - 1) begin
                        m_segs.push_back(1);
                        m_mark.push_back(1'b0);
                    end
                end
                m_segs.push_back(GAP_UNITS);
                m_mark.push_back(1'b0);
                m_seg   = 0;
                m_left  = m_segs[0];
                m_phase = 2;
            end
            default: if (t) begin
                m_left--;
                if (m_left == 0) begin
                    m_seg++;
                    if (m_seg == m_segs.size()) begin
                        m_phase = 0;
                        m_done  = 1'b1;
                    end else begin
                        m_left = m_segs[m_seg];
                    end
                end
            end
        endcase
        if (v && rdy)
            m_q.push_back(l);
    endtask

    task automatic check_all();
        bit e_light;
        e_light = (m_phase == 2) && m_mark[m_seg];
        check("light", light_o, e_light);
        check("busy", busy_o, m_phase != 0);
        check("fifo_count", fifo_count_o, m_q.size());
        check("ready", letter_ready_o, m_q.size() < FIFO_DEPTH);
        check("done", letter_done_o, m_done);
    endtask

    // Inputs change just after a falling edge; outputs are checked at the next falling edge.
    task automatic cyc(input bit v, input int l, input bit t);
        letter_valid_i = v;
        letter_i       = 3'(l);
        tick_i         = t;
        @(posedge clk);
        model_step(v, l, t);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_cycles(input int n, input bit t);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, t);
    endtask

    initial begin
        int dens;
        int tcnt;
        rst_n          = 1'b0;
        tick_i         = 1'b0;
        letter_i       = 3'd0;
        letter_valid_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_light", light_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_count", fifo_count_o, 0);
        check("rst_ready", letter_ready_o, 1'b1);
        check("rst_done", letter_done_o, 1'b0);
        rst_n = 1'b1;

        // Single letters with tick held high: E, A, B.
        cyc(1'b1, 4, 1'b1);
        idle_cycles(10, 1'b1);
        cyc(1'b1, 0, 1'b1);
        idle_cycles(14, 1'b1);
        cyc(1'b1, 1, 1'b1);
        idle_cycles(18, 1'b1);

        // G with tick every fourth clock.
        cyc(1'b1, 6, 1'b0);
        tcnt = 0;
        for (int i = 0; i < 90; i++) begin
            cyc(1'b0, 0, (tcnt % 4) == 3);
            tcnt++;
        end

        // Fill the queue while time is frozen, then drain.
        for (int i = 0; i < 8; i++) cyc(1'b1, i, 1'b0);
        idle_cycles(150, 1'b1);

        // Back-to-back letters exercising push on the pop edge.
        cyc(1'b1, 4, 1'b1);
        cyc(1'b1, 4, 1'b1);
        idle_cycles(6, 1'b1);
        cyc(1'b1, 7, 1'b1);
        idle_cycles(40, 1'b1);

        // Reset in the middle of a dash with a letter still queued.
        cyc(1'b1, 6, 1'b0);
        idle_cycles(3, 1'b0);
        cyc(1'b1, 3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_light", light_o, 1'b0);
        check("arst_count", fifo_count_o, 0);
        check("arst_done", letter_done_o, 1'b0);
        check("arst_busy", busy_o, 1'b0);
        letter_valid_i = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        cyc(1'b1, 4, 1'b1);
        idle_cycles(10, 1'b1);

        // Random letters and tick densities.
        for (int b = 0; b < 6; b++) begin
            dens = $urandom_range(1, 4);
            for (int i = 0; i < 500; i++)
                cyc(($urandom % 4) == 0, $urandom_range(0, 7), $urandom_range(0, dens - 1) == 0);
        end
        idle_cycles(300, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/morse_sequencer.md
# morse_sequencer

Control block that queues 3-bit letter codes (A–H) from a requester and sequences their transmission as standard-ratio Morse on a single light output. It holds the letter-to-symbol table and times each mark, inter-symbol space and inter-letter gap in units of an external time-base strobe. It sits between the switch/button front end and the LED: the requester pushes letters via a ready/valid handshake, and the sequencer owns the light until its queue drains.

## Interface
- FIFO_DEPTH, 4, letter queue entries (power of two, ≥2)
- DOT_UNITS, 1, ticks of light-on for a dot
- DASH_UNITS, 3, ticks of light-on for a dash
- LETTER_GAP_UNITS, 3, ticks of light-off after a letter's last symbol
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- tick  in  1  one-cycle time-unit strobe (e.g. half-second enable)
- letter_in  in  3  letter code, 0=A … 7=H
- letter_valid  in  1  requester offers letter_in
- letter_ready  out  1  queue can accept (count < FIFO_DEPTH)
- light  out  1  Morse output, registered
- busy  out  1  high in any state other than IDLE
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued letters, not counting the one in flight
- letter_done  out  1  one-cycle pulse when a letter's trailing gap completes

## Operation
- Symbol table (first symbol sent first): A .-, B -..., C -.-., D -.., E ., F ..-., G --., H .... ; length 1–4 stored with pattern.
- Push: on clk edge with letter_valid && letter_ready, letter_in is written at the tail. Letter_ready is combinational from count only (low when count == FIFO_DEPTH).
- States: IDLE, LOAD, MARK, SPACE, GAP.
- IDLE: if fifo_count != 0, pop the head and go to LOAD; else stay. A push and pop on the same edge are both honoured (count unchanged).
- LOAD: one cycle; latch symbol length/pattern, load unit counter with DOT_UNITS or DASH_UNITS for the first symbol; go to MARK.
- MARK: light = 1. Each tick decrements the unit counter; on the tick that finishes it: if symbols remain, go to SPACE with counter = 1; else go to GAP with counter = LETTER_GAP_UNITS.
- SPACE: light = 0; on the finishing tick load the next symbol's units, go to MARK.
- GAP: light = 0; on the finishing tick pulse letter_done for the next cycle and return to IDLE.
- tick is ignored in IDLE and LOAD; a state entered on an edge counts only ticks sampled on later edges.
- Unit counter width: $clog2(max(DASH_UNITS, LETTER_GAP_UNITS))+1; parameters of 0 are illegal.
- Letters are never dropped or reordered; the requester stalls while letter_ready is low.

## Timing
- Reset (async assert): light=0, busy=0, letter_done=0, fifo_count=0, letter_ready=1, state=IDLE, queue pointers cleared. Reset mid-letter aborts it with no letter_done.
- Push-to-light latency from an empty idle sequencer: light rises 2 clocks after the push edge (pop edge, LOAD edge), independent of tick.
- With tick held high: a dot is 1 clock of light, a dash 3, spaces 1 clock, gap 3 clocks.
- Letter back-to-back: after GAP→IDLE, the next letter's light rises 2 clocks later (IDLE pop, LOAD); these cycles add to the gap.
- letter_done is registered and asserts exactly one cycle per completed letter.

## Test plan
- Single E, tick=1 constant, push at edge 0 -> light high for exactly clock 2–3, busy high edges 1–6, letter_done pulse after edge 6, fifo_count 1 for one cycle then 0.
- Single A, tick=1 -> light sequence from LOAD exit: 1,0,1,1,1 then 0 for 3 clocks, then letter_done; B gives 1,1,1,0,1,0,1,0,1.
- Tick every 4th clock, letter G -> each dash high for 12 clocks, inter-symbol space 4 clocks, gap 12 clocks (± phase of first tick).
- Queue fill: tick=0, letter_valid held 8 clocks with codes 0..7 -> exactly 5 accepted (1 popped into LOAD/MARK), fifo_count=4, letter_ready low; then tick=1 -> letters emitted in order 0..4, each with one letter_done.
- Simultaneous push/pop: count=1 in IDLE, push same edge as pop -> fifo_count stays 1, both letters sent in order.
- Reset asserted mid-dash -> light 0 immediately (before next edge), fifo_count 0, no letter_done; after release a new push behaves as from power-up.
